// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA line-buffer path.
package vga_pkg;

  localparam int LINE_PIXELS  = 481;
  localparam int VISIBLE_ROWS = 480;
  localparam int ROW_CYCLES   = 640;
  localparam int FRAME_PIXELS = 307200;
  localparam int ADDR_W       = 9;
  localparam int SYNC_ROW     = 478;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_FILL    = 2'd2,
    ST_WAIT    = 2'd3
  } sched_state_t;

  // Row arithmetic modulo the frame height; row and step are both below rows.
  function automatic logic [ADDR_W-1:0] row_wrap_add(
    input logic [ADDR_W-1:0] row,
    input logic [ADDR_W-1:0] step,
    input logic [ADDR_W:0]   rows
  );
    logic [ADDR_W:0] sum;
    sum = {1'b0, row} + {1'b0, step};
    if (sum >= rows) begin
      sum = sum - rows;
    end else begin
      sum = sum;
    end
    return sum[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/vga_fill_counter.sv
// Beat counter for line-buffer addressing: clear wins over increment,
// and the count wraps to zero after the final beat of a line.
module vga_fill_counter #(
  parameter int W   = 9,
  parameter int MAX = 481
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_last
);

  localparam logic [W-1:0] L_LAST = W'(MAX - 1);
  localparam logic [W-1:0] L_ONE  = W'(1);

  logic [W-1:0] r_count;

  // Advance on each accepted beat; restart at zero on clear or after the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      if (r_count == L_LAST) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + L_ONE;
      end
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == L_LAST);

endmodule

// File: rtl/vga_line_scheduler.sv
// Ping-pong line-buffer scheduler: requests rows from the pixel source,
// writes them into the idle bank, swaps banks on next_row and flags
// fill underruns and frame-sync errors.
module vga_line_scheduler #(
  parameter int LINE_PIXELS  = vga_pkg::LINE_PIXELS,
  parameter int VISIBLE_ROWS = vga_pkg::VISIBLE_ROWS,
  parameter int ADDR_W       = vga_pkg::ADDR_W,
  parameter int SYNC_ROW     = vga_pkg::SYNC_ROW
) (
  input  logic              clock_vga,
  input  logic              reset,
  input  logic              enable,
  input  logic              next_row,
  input  logic              next_screen,
  output logic              row_req,
  output logic [ADDR_W-1:0] row_idx,
  input  logic              pix_valid,
  input  logic [23:0]       pix_data,
  output logic              pix_ready,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              rd_bank,
  output logic              start,
  output logic              underrun,
  output logic              sync_err,
  output logic [15:0]       frame_count
);

  import vga_pkg::*;

  localparam logic [ADDR_W:0]   L_ROWS = (ADDR_W + 1)'(VISIBLE_ROWS);
  localparam logic [ADDR_W-1:0] L_SYNC = ADDR_W'(SYNC_ROW);
  localparam logic [ADDR_W-1:0] L_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] L_TWO  = ADDR_W'(2);

  sched_state_t      r_state;
  logic              r_row_req;
  logic [ADDR_W-1:0] r_row_idx;
  logic              r_pix_ready;
  logic              r_wr_en;
  logic              r_wr_bank;
  logic [ADDR_W-1:0] r_wr_addr;
  pixel_t            r_wr_data;
  logic              r_rd_bank;
  logic              r_start;
  logic              r_underrun;
  logic              r_sync_err;
  logic [15:0]       r_frame_count;
  logic [ADDR_W-1:0] r_disp_row;
  // Last beat of the current row was accepted; its write is on the bus now,
  // and the row is treated as complete from the next cycle on.
  logic              r_last_pend;

  logic              w_swap;
  logic              w_xfer;
  logic              w_cnt_clr;
  logic [ADDR_W-1:0] w_beat;
  logic              w_beat_last;

  // A swap only happens once the display is running; a beat arriving in the
  // swap cycle belongs to the aborted row and is discarded.
  assign w_swap    = next_row & ((r_state == ST_FILL) | (r_state == ST_WAIT));
  assign w_xfer    = pix_valid & r_pix_ready & ~w_swap;
  assign w_cnt_clr = ((r_state == ST_IDLE) & enable) | w_swap |
                     ((r_state == ST_PREFILL) & r_last_pend);

  vga_fill_counter #(
    .W   (ADDR_W),
    .MAX (LINE_PIXELS)
  ) u_fill_counter (
    .clk     (clock_vga),
    .rst     (reset),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_xfer),
    .o_count (w_beat),
    .o_last  (w_beat_last)
  );

  // Scheduler state machine with all outputs registered.
  always_ff @(posedge clock_vga or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_row_req     <= 1'b0;
      r_row_idx     <= '0;
      r_pix_ready   <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_bank     <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= 24'h000000;
      r_rd_bank     <= 1'b0;
      r_start       <= 1'b0;
      r_underrun    <= 1'b0;
      r_sync_err    <= 1'b0;
      r_frame_count <= 16'h0000;
      r_disp_row    <= '0;
      r_last_pend   <= 1'b0;
    end else begin
      r_row_req <= 1'b0;
      r_wr_en   <= 1'b0;

      if (w_xfer) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= w_beat;
        r_wr_data <= pix_data;
        if (w_beat_last) begin
          r_last_pend <= 1'b1;
          r_pix_ready <= 1'b0;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_row_req   <= 1'b1;
            r_row_idx   <= '0;
            r_wr_bank   <= 1'b0;
            r_pix_ready <= 1'b1;
            r_state     <= ST_PREFILL;
          end
        end
        ST_PREFILL: begin
          if (r_last_pend) begin
            r_last_pend <= 1'b0;
            r_start     <= 1'b1;
            r_row_req   <= 1'b1;
            r_row_idx   <= L_ONE;
            r_wr_bank   <= 1'b1;
            r_pix_ready <= 1'b1;
            r_state     <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (r_last_pend) begin
            r_last_pend <= 1'b0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_pix_ready <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      // Bank swap overrides whatever the fill path decided this cycle.
      if (w_swap) begin
        if ((r_state == ST_FILL) && !r_last_pend) begin
          r_underrun <= 1'b1;
        end
        r_rd_bank   <= ~r_rd_bank;
        r_wr_bank   <= r_rd_bank;
        r_row_idx   <= row_wrap_add(r_disp_row, L_TWO, L_ROWS);
        r_disp_row  <= row_wrap_add(r_disp_row, L_ONE, L_ROWS);
        r_row_req   <= 1'b1;
        r_last_pend <= 1'b0;
        r_pix_ready <= 1'b1;
        r_state     <= ST_FILL;
      end

      // Frame accounting uses the display row before any same-cycle swap.
      if (next_screen) begin
        r_frame_count <= r_frame_count + 16'd1;
        if (r_disp_row != L_SYNC) begin
          r_sync_err <= 1'b1;
        end
      end
    end
  end

  assign row_req     = r_row_req;
  assign row_idx     = r_row_idx;
  assign pix_ready   = r_pix_ready;
  assign wr_en       = r_wr_en;
  assign wr_bank     = r_wr_bank;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign rd_bank     = r_rd_bank;
  assign start       = r_start;
  assign underrun    = r_underrun;
  assign sync_err    = r_sync_err;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_line_scheduler.sv
// Self-checking bench for vga_line_scheduler with a behavioural reference model.
module tb_vga_line_scheduler;

  logic        clock_vga = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        next_row = 1'b0;
  logic        next_screen = 1'b0;
  logic        row_req;
  logic [8:0]  row_idx;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_data = 24'h0;
  logic        pix_ready;
  logic        wr_en;
  logic        wr_bank;
  logic [8:0]  wr_addr;
  logic [23:0] wr_data;
  logic        rd_bank;
  logic        start;
  logic        underrun;
  logic        sync_err;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;

  vga_line_scheduler dut (
    .clock_vga   (clock_vga),
    .reset       (reset),
    .enable      (enable),
    .next_row    (next_row),
    .next_screen (next_screen),
    .row_req     (row_req),
    .row_idx     (row_idx),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_ready   (pix_ready),
    .wr_en       (wr_en),
    .wr_bank     (wr_bank),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_bank     (rd_bank),
    .start       (start),
    .underrun    (underrun),
    .sync_err    (sync_err),
    .frame_count (frame_count)
  );

  always #5 clock_vga = ~clock_vga;

  // Reference model: phase 0=idle, 1=first row loading, 2=loading, 3=row ready.
  int      m_phase;
  int      m_beats;      // pixels received for the row being loaded
  bit      m_done_next;  // row finished, its completion takes effect next cycle
  int      m_load_bank;
  int      m_show_bank;
  int      m_show_row;
  int      m_req_row;
  bit      m_req;
  bit      m_wr;
  int      m_wr_addr;
  int      m_wr_data;
  bit      m_start;
  bit      m_under;
  bit      m_sync;
  int      m_frames;

  task automatic model_reset();
    m_phase = 0; m_beats = 0; m_done_next = 0; m_load_bank = 0; m_show_bank = 0;
    m_show_row = 0; m_req_row = 0; m_req = 0; m_wr = 0; m_wr_addr = 0; m_wr_data = 0;
    m_start = 0; m_under = 0; m_sync = 0; m_frames = 0;
  endtask

  task automatic model_step(input bit en, input bit pv, input logic [23:0] pd,
                            input bit nr, input bit ns);
    bit accepting;
    int shown_before;
    accepting    = (m_phase == 1 || m_phase == 2) && !m_done_next;
    shown_before = m_show_row;
    m_req = 0;
    m_wr  = 0;
    if (m_phase == 0) begin
      if (en) begin
        m_req = 1; m_req_row = 0; m_load_bank = 0; m_beats = 0; m_phase = 1;
      end
    end else if (nr && (m_phase == 2 || m_phase == 3)) begin
      if (m_phase == 2 && !m_done_next) m_under = 1;
      m_load_bank = m_show_bank;
      m_show_bank = 1 - m_show_bank;
      m_req_row   = (m_show_row + 2) % 480;
      m_show_row  = (m_show_row + 1) % 480;
      m_req = 1; m_beats = 0; m_done_next = 0; m_phase = 2;
    end else if (m_done_next) begin
      m_done_next = 0;
      if (m_phase == 1) begin
        m_start = 1; m_req = 1; m_req_row = 1; m_load_bank = 1; m_beats = 0; m_phase = 2;
      end else begin
        m_phase = 3;
      end
    end else if (accepting && pv) begin
      m_wr = 1; m_wr_addr = m_beats; m_wr_data = int'(pd);
      m_beats = m_beats + 1;
      if (m_beats == 481) begin
        m_beats = 0; m_done_next = 1;
      end
    end
    if (ns) begin
      m_frames = (m_frames + 1) % 65536;
      if (shown_before != 478) m_sync = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("row_req",     32'(row_req),     32'(m_req));
    chk("row_idx",     32'(row_idx),     32'(m_req_row));
    chk("pix_ready",   32'(pix_ready),   32'((m_phase == 1 || m_phase == 2) && !m_done_next));
    chk("wr_en",       32'(wr_en),       32'(m_wr));
    chk("wr_bank",     32'(wr_bank),     32'(m_load_bank));
    chk("rd_bank",     32'(rd_bank),     32'(m_show_bank));
    chk("start",       32'(start),       32'(m_start));
    chk("underrun",    32'(underrun),    32'(m_under));
    chk("sync_err",    32'(sync_err),    32'(m_sync));
    chk("frame_count", 32'(frame_count), 32'(m_frames));
    if (m_wr) begin
      chk("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
      chk("wr_data", 32'(wr_data), 32'(m_wr_data));
    end
  endtask

  // One clock: drive inputs, let the edge pass, compare against the model.
  task automatic step(input bit en, input bit pv, input bit nr, input bit ns);
    logic [23:0] pd;
    pd          = 24'($urandom);
    enable      = en;
    pix_valid   = pv;
    pix_data    = pd;
    next_row    = nr;
    next_screen = ns;
    @(posedge clock_vga);
    #1;
    model_step(en, pv, pd, nr, ns);
    check_all();
    next_row    = 1'b0;
    next_screen = 1'b0;
  endtask

  task automatic fill_to_ready(input bit stalls);
    int n;
    n = 0;
    while (m_phase != 3 && n < 3000) begin
      step(1'b1, stalls ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0, 1'b0);
      n++;
    end
    chk("fill_done_ready", 32'(pix_ready), 32'd0);
  endtask

  initial begin
    bit seen478;
    bit seen100;
    int n;
    model_reset();
    #1 reset = 1'b1;
    #2;
    check_all();
    @(posedge clock_vga);
    #1 reset = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b0, $urandom_range(0, 1) == 1, 1'b0, 1'b0);

    // Prefill row 0 with no stalls, then row 1 with random stalls.
    n = 0;
    while (m_phase != 2 && n < 2000) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      n++;
    end
    chk("prefill_start", 32'(start), 32'd1);
    chk("prefill_req_row1", 32'(row_idx), 32'd1);
    fill_to_ready(1'b1);

    // Steady state: complete rows, then swap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) step(1'b1, $urandom_range(0, 1) == 1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      fill_to_ready(1'b1);
    end
    chk("no_underrun_yet", 32'(underrun), 32'd0);

    // Underrun: only 300 beats before the next swap.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("underrun_set", 32'(underrun), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("restart_addr0", 32'(wr_addr), 32'd0);

    // Walk the display row through a full wrap with frame pulses.
    seen478 = 0;
    seen100 = 0;
    for (int i = 0; i < 1200 && !seen100; i++) begin
      if (m_show_row == 478 && !seen478) begin
        step(1'b1, $urandom_range(0, 1) == 1, 1'b0, 1'b1);
        chk("sync_ok_478", 32'(sync_err), 32'd0);
        seen478 = 1;
      end else if (m_show_row == 100 && seen478) begin
        step(1'b1, $urandom_range(0, 1) == 1, 1'b1, 1'b1);
        chk("sync_err_100", 32'(sync_err), 32'd1);
        seen100 = 1;
      end else begin
        step(1'b1, $urandom_range(0, 1) == 1, 1'b1, 1'b0);
      end
      step(1'b1, $urandom_range(0, 1) == 1, 1'b0, 1'b0);
    end

    // Reset in the middle of a fill, right after beat 200 is written.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (m_beats != 201 && n < 1000) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      n++;
    end
    chk("midfill_wr_en", 32'(wr_en), 32'd1);
    reset = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge clock_vga);
    #1 reset = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("restart_row_req", 32'(row_req), 32'd1);
    for (int i = 0; i < 20; i++) step(1'b1, $urandom_range(0, 1) == 1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_line_scheduler.md
Name: vga_line_scheduler

Overview:
- Sequences a ping-pong pair of 512-entry line buffers that feed the VGA pixel streamer.
- Requests each upcoming row from the pixel source (square/game renderer) and writes the returned pixels into the idle bank.
- Swaps banks on the streamer's next_row pulse and releases the streamer's start once the first row is resident.
- Detects row-fill underrun and frame-sync errors.

Parameters:
LINE_PIXELS, 481, pixels written per row (matches the 481-cycle drawing window, addresses 0..480)
VISIBLE_ROWS, 480, rows per frame
ADDR_W, 9, line-buffer address width
SYNC_ROW, 478, display row index during which next_screen must arrive

Ports:
clock_vga  in  1  pixel clock, sole clock
reset  in  1  asynchronous, active-high reset
enable  in  1  level; begins prefill when high in IDLE
next_row  in  1  from streamer; 1-cycle pulse near end of each displayed row
next_screen  in  1  from streamer; 1-cycle pulse once per frame
row_req  out  1  1-cycle pulse requesting a row from the source
row_idx  out  9  row requested; valid with row_req, held until the next request
pix_valid  in  1  source pixel valid
pix_data  in  24  source pixel {R,G,B}
pix_ready  out  1  controller accepts pixel
wr_en  out  1  line-buffer write strobe
wr_bank  out  1  bank being written
wr_addr  out  9  write address
wr_data  out  24  write data
rd_bank  out  1  bank the streamer reads
start  out  1  streamer enable; sticky once set
underrun  out  1  sticky; a fill was incomplete at a bank swap
sync_err  out  1  sticky; next_screen arrived outside SYNC_ROW
frame_count  out  16  completed frames, wraps

Behaviour:
- Reset (async) values: every output 0; state IDLE; internal display row = 0; fill row = 0.
- States: IDLE, PREFILL, FILL, WAIT.
- IDLE: on enable=1, pulse row_req with row_idx=0, write bank 0, go to PREFILL.
- PREFILL/FILL: pix_ready=1. A pixel transfers on pix_valid & pix_ready.
  - Each transfer: wr_en=1, wr_data=pix_data, wr_addr = beat count (0..LINE_PIXELS-1), all registered with 1-cycle latency.
  - When beat LINE_PIXELS-1 is written:
    - From PREFILL: set start=1 in the following cycle, pulse row_req with row_idx=1 into bank 1, go to FILL.
    - From FILL: go to WAIT with pix_ready=0.
- next_row, in any state except IDLE/PREFILL:
  - rd_bank toggles in the next cycle; display row increments, wrapping VISIBLE_ROWS-1 -> 0.
  - wr_bank = new idle bank (old rd_bank).
  - row_req pulses with row_idx = display row + 2 mod VISIBLE_ROWS (the row after the one now shown).
  - Write beat count resets to 0; state becomes FILL.
- next_row while in FILL (previous fill incomplete):
  - Set underrun.
  - Drop the remaining beats of the aborted row; it remains the source's duty to restart on row_req.
  - Then perform the normal swap and new request.
- next_row in IDLE/PREFILL: ignored.
- next_screen: frame_count increments, wrapping at 0xFFFF. If display row != SYNC_ROW, set sync_err. No state change.
- next_row and next_screen in the same cycle: both take effect. The sync check uses the pre-increment display row.
- enable deassert: no effect after leaving IDLE. Only reset returns to IDLE.
- Reset mid-fill: everything returns to reset values immediately. wr_en drops asynchronously.
- pix_valid while pix_ready=0: ignored; no write.
- wr_addr never exceeds LINE_PIXELS-1. Extra beats are impossible because pix_ready drops in WAIT.

Decomposition:
- Shared package vga_pkg holds:
  - Constants: LINE_PIXELS, VISIBLE_ROWS, ROW_CYCLES=640, FRAME_PIXELS=307200.
  - Typedef pixel_t (24-bit RGB).
  - State enum sched_state_t.
- Sub-module vga_fill_counter: beat counter with clear/increment/last flag. Reused by the streamer-side address logic.

Test Plan:
- Reset then enable=1; source supplies 481 beats with no stalls -> row_req(row 0); wr_addr 0..480 on bank 0; start=1 one cycle after beat 480; row_req(row 1) on bank 1.
- Steady state; pulse next_row after fill completes -> rd_bank toggles next cycle; row_req row_idx=2; wr_bank=0; underrun stays 0.
- Source stalls so only 300 beats arrive before next_row -> underrun=1 (sticky); beat count restarts at 0 on the new bank; new row_req issued.
- Drive 480 next_row pulses -> row_idx wraps 479 -> 0 -> 1; display row wraps to 0.
- next_screen while display row=478 -> frame_count+1, sync_err=0. next_screen at row 100 -> sync_err=1.
- Assert reset during FILL at beat 200 -> all outputs 0 asynchronously. After release with enable=1 -> restart from row_req(row 0) in PREFILL.
